uart_tx_ctrl: RTL

Framing controller for the MIPS UART transmit path. It accepts a byte from the processor side over a valid/ready handshake and drives the `load`/`enable` controls and parallel data of the downstream loadable right-shift register. It consumes that register's registered serial bit (`Q`) and builds the line frame: start bit, LSB-first data, optional parity, stop bit. It sits between the memory-mapped UART TX register and the shift register.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   DEF_CLKS_PER_BIT = 868;
    localparam int   DEF_DATA_W       = 8;
    localparam logic LINE_IDLE        = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and wraps, held at zero while clr_i is high.
// Exposes end-of-bit (last) and one-before-end (pre_last) flags.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             pre_last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_last_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    assign cnt_o      = cnt_q;

    // Wrapping at the bit end is what clears the count on every state change.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || last_o)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller driving an external loadable right-shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              sh_load,
    output logic              sh_enable,
    output logic [DATA_W-1:0] sh_data,
    input  logic              sh_q,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_e        state_q;
    logic [IDX_W-1:0] idx_q;
    logic             done_q;
    logic             busy_q;
    logic             accept;
    logic             bit_last;
    logic             bit_pre_last;
    logic [CNT_W-1:0] cnt_unused;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    // The controller only needs the flags; the raw count stays on the port for debug.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == ST_IDLE),
        .cnt_o      (cnt_unused),
        .last_o     (bit_last),
        .pre_last_o (bit_pre_last)
    );

    assign tx_ready = (state_q == ST_IDLE);
    assign accept   = tx_valid & tx_ready;
    assign sh_load  = accept;
    assign sh_data  = tx_data;
    // Shift one cycle early: the register's Q lags enable by two edges.
    assign sh_enable = (state_q == ST_DATA) && bit_pre_last &&
                       (idx_q != IDX_W'(DATA_W - 1));
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_START;
                        busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        state_q <= ST_DATA;
                        idx_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_last)
                        state_q <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (bit_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        tx = LINE_IDLE;
        case (state_q)
            ST_START:  tx = ~LINE_IDLE;
            ST_DATA:   tx = sh_q;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            default:   tx = LINE_IDLE;
        endcase
    end

endmodule
